// File: rtl/plic_src_conditioner.sv
// plic_src_conditioner: synchronises and glitch-filters interrupt lines feeding PLIC src; `PLIC_SRC_INVERT_EN adds per-source inversion (inv port)
module plic_src_conditioner #(
  parameter int SOURCES       = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [SOURCES-1:0] src_i,
  input  logic [SOURCES-1:0] bypass,
`ifdef PLIC_SRC_INVERT_EN
  input  logic [SOURCES-1:0] inv,
`endif
  output logic [SOURCES-1:0] src_o,
  output logic [SOURCES-1:0] glitch
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [SOURCES-1:0] raw;
  logic [SOURCES-1:0] s;
  logic [SYNC_STAGES-1:0][SOURCES-1:0] sync_q;
`ifdef PLIC_SRC_INVERT_EN
  assign raw = src_i ^ inv;
`else
  assign raw = src_i;
`endif
  assign s = sync_q[SYNC_STAGES-1];
  // synchroniser chain, newest sample in stage 0
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  genvar g;
  for (g = 0; g < SOURCES; g++) begin : g_src
    logic [CW-1:0] cnt_q, cnt_d;
    logic q_q, q_d, glitch_q, glitch_d;
    logic diff, last;
    // a new level must be seen FILTER_CYCLES times in a row before it commits; an aborted run flags a glitch
    always_comb begin
      diff     = s[g] ^ q_q;
      last     = cnt_q == CW'(FILTER_CYCLES - 1);
      q_d      = (bypass[g] || (diff && last)) ? s[g] : q_q;
      cnt_d    = (bypass[g] || !diff || last) ? '0 : cnt_q + CW'(1);
      glitch_d = !bypass[g] && !diff && cnt_q != '0;
    end
    // per-source filter state, cleared asynchronously
    always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
        cnt_q    <= '0;
        q_q      <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        q_q      <= q_d;
        glitch_q <= glitch_d;
      end
    assign src_o[g]  = q_q;
    assign glitch[g] = glitch_q;
  end
endmodule
